// File: rtl/ibuf_pkg.sv
// ---------------------------------------------------------------------------
// ibuf_pkg
// Shared constants for the ibuffer geometry and the read-burst FSM encoding.
//   IBUF_ADDR_W / IBUF_DATA_W : word address and word data widths
//   IBUF_BANKS x IBUF_BANK_DEPTH words; bank = addr[14:10]
//   IBUF_ADDR_MAX             : last legal word address
// ---------------------------------------------------------------------------
package ibuf_pkg;

    localparam int IBUF_ADDR_W     = 15;
    localparam int IBUF_DATA_W     = 128;
    localparam int IBUF_BANKS      = 24;
    localparam int IBUF_BANK_DEPTH = 1024;
    localparam int IBUF_ADDR_MAX   = IBUF_BANKS * IBUF_BANK_DEPTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ibuf_rd_fifo.sv
// ---------------------------------------------------------------------------
// ibuf_rd_fifo
// Synchronous FIFO, DEPTH x WIDTH, first-word-fall-through read port with an
// occupancy count. DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst_n          clock, async active-low reset (control only)
//   wr_en, wr_data      push; accepted when not full, or when full with a pop
//   rd_en               pop of the head entry when not empty
//   rd_data             head entry, forced to 0 while empty
//   full, empty, count  status
// ---------------------------------------------------------------------------
module ibuf_rd_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PW'(1);
            if (do_rd) rptr <= rptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/ibuf_rd_burst_gen.sv
// ---------------------------------------------------------------------------
// ibuf_rd_burst_gen
// Read-burst engine in front of ibuffer port a. Takes one descriptor
// (start address, beats-1), issues consecutive word reads with a last flag,
// collects returns in a credit-protected FIFO and streams them out.
// Ports:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len    descriptor handshake
//   ibuf_cen/ibuf_wen/ibuf_addr/ibuf_last   request to ibuffer (wen tied 0)
//   ibuf_ready                              ibuffer accepts the request
//   ibuf_rdata/ibuf_rvalid/ibuf_rlast       returned data
//   ibuf_rready                             FIFO not full
//   m_valid/m_data/m_last/m_ready           output stream
//   busy                                    burst in progress (not IDLE)
//   done                                    1-cycle pulse after final return
//   err                                     sticky rlast mismatch
// ---------------------------------------------------------------------------
module ibuf_rd_burst_gen
    import ibuf_pkg::*;
#(
    parameter int DATA_W     = IBUF_DATA_W,
    parameter int ADDR_W     = IBUF_ADDR_W,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_MAX   = IBUF_ADDR_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              ibuf_cen,
    output logic              ibuf_wen,
    output logic [ADDR_W-1:0] ibuf_addr,
    output logic              ibuf_last,
    input  logic              ibuf_ready,
    input  logic [DATA_W-1:0] ibuf_rdata,
    input  logic              ibuf_rvalid,
    input  logic              ibuf_rlast,
    output logic              ibuf_rready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  ret_cnt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic              err_q;
    logic              done_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rd;
    logic              credit_ok;
    logic              req_fire;
    logic              ret_push;
    logic              ret_final;
    logic              cmd_acc;

    function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(ADDR_MAX)) ? '0 : a + ADDR_W'(1);
    endfunction

    // Requests in flight plus words already buffered may never exceed the
    // FIFO size, so every return is guaranteed a slot.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign req_fire  = (state == ST_ISSUE) && credit_ok && ibuf_ready;
    assign ret_push  = ibuf_rvalid && ibuf_rready;
    assign ret_final = (ret_cnt == '0);
    assign cmd_acc   = cmd_valid && (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        ibuf_cen  = 1'b0;
        ibuf_last = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                ibuf_cen  = credit_ok;
                ibuf_last = (issue_cnt == '0);
                if (req_fire && (issue_cnt == '0)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ret_push && ret_final) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_DRAIN) && ret_push && ret_final;

            if (cmd_acc) begin
                addr_q    <= cmd_addr;
                issue_cnt <= cmd_len;
                ret_cnt   <= cmd_len;
            end else begin
                if (req_fire) begin
                    addr_q <= addr_wrap_inc(addr_q);
                    if (issue_cnt != '0) issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (ret_push && !ret_final) ret_cnt <= ret_cnt - LEN_W'(1);
            end

            // rlast must agree with the locally counted final beat.
            if (cmd_acc)
                err_q <= 1'b0;
            else if (ret_push && (state != ST_IDLE) && (ibuf_rlast != ret_final))
                err_q <= 1'b1;

            case ({req_fire, ret_push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    ibuf_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ret_push),
        .wr_data ({ret_final, ibuf_rdata}),
        .rd_en   (m_ready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ibuf_wen    = 1'b0;
    assign ibuf_addr   = addr_q;
    assign ibuf_rready = !fifo_full;
    assign m_valid     = !fifo_empty;
    assign m_data      = fifo_rd[DATA_W-1:0];
    assign m_last      = fifo_rd[DATA_W];
    assign busy        = (state != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(ibuf_rvalid && fifo_full));
    a_cmd_addr_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_valid && cmd_ready) |-> (cmd_addr <= ADDR_W'(ADDR_MAX)));
`endif

endmodule

// File: tb/tb_ibuf_rd_burst_gen.sv
module tb_ibuf_rd_burst_gen;
    import ibuf_pkg::*;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 15;
    localparam int LEN_W      = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_MAX   = 24575;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              ibuf_cen;
    logic              ibuf_wen;
    logic [ADDR_W-1:0] ibuf_addr;
    logic              ibuf_last;
    logic              ibuf_ready;
    logic [DATA_W-1:0] ibuf_rdata;
    logic              ibuf_rvalid;
    logic              ibuf_rlast;
    logic              ibuf_rready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    ibuf_rd_burst_gen #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_MAX(ADDR_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ibuf_cen(ibuf_cen), .ibuf_wen(ibuf_wen), .ibuf_addr(ibuf_addr), .ibuf_last(ibuf_last),
        .ibuf_ready(ibuf_ready), .ibuf_rdata(ibuf_rdata), .ibuf_rvalid(ibuf_rvalid),
        .ibuf_rlast(ibuf_rlast), .ibuf_rready(ibuf_rready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: totals across bursts plus the current burst's progress.
    logic [ADDR_W-1:0] mem_addr_q[$];
    logic              mem_last_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic              exp_last_q[$];
    logic [ADDR_W-1:0] fire_log[$];
    logic              fire_last_log[$];
    logic              mlast_log[$];
    int                tot_fired, tot_pushed, tot_popped;
    bit                active;
    int                b_len, b_fired, b_pushed;
    logic [ADDR_W-1:0] b_next_addr;
    bit                err_exp, done_exp;
    int                done_cnt;
    int                inj_beat = -1;
    int                p_ready = 100, p_mready = 100, p_rvalid = 100;
    logic [31:0]       salt;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = {17'b0, a};
        return {salt ^ x, x * 32'h9E37_79B1, ~(salt + x), x ^ {salt[15:0], salt[31:16]}};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mem_addr_q.delete(); mem_last_q.delete();
        exp_data_q.delete(); exp_last_q.delete();
        tot_fired = 0; tot_pushed = 0; tot_popped = 0;
        active = 0; b_len = 0; b_fired = 0; b_pushed = 0; b_next_addr = '0;
        err_exp = 0; done_exp = 0;
    endtask

    task automatic drive_idle();
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        ibuf_ready = 0; ibuf_rvalid = 0; ibuf_rdata = '0; ibuf_rlast = 0; m_ready = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_ibuf_cen"},  ibuf_cen, 0);
        check({tag, "_ibuf_wen"},  ibuf_wen, 0);
        check({tag, "_ibuf_addr"}, ibuf_addr, 0);
        check({tag, "_ibuf_last"}, ibuf_last, 0);
        check({tag, "_m_valid"},   m_valid, 0);
        check({tag, "_m_data"},    m_data, 0);
        check({tag, "_m_last"},    m_last, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_err"},       err, 0);
    endtask

    // One clock: compare at the falling edge, drive new inputs, then advance
    // the model by the handshakes that the coming rising edge will take.
    task automatic step(input bit cv, input logic [ADDR_W-1:0] ca, input logic [LEN_W-1:0] cl,
                        output bit acc);
        int  occ, outs;
        bit  exp_cen, fire, push, pop;
        @(negedge clk);
        occ  = tot_pushed - tot_popped;
        outs = tot_fired - tot_pushed;
        exp_cen = active && (b_fired <= b_len) && ((outs + occ) < FIFO_DEPTH);
        check("cmd_ready", cmd_ready, !active);
        check("busy", busy, active);
        check("done", done, done_exp);
        check("err", err, err_exp);
        check("ibuf_wen", ibuf_wen, 0);
        check("ibuf_cen", ibuf_cen, exp_cen);
        if (exp_cen) begin
            check("ibuf_addr", ibuf_addr, b_next_addr);
            check("ibuf_last", ibuf_last, (b_fired == b_len));
        end
        check("ibuf_rready", ibuf_rready, (occ < FIFO_DEPTH));
        check("m_valid", m_valid, (occ > 0));
        if (occ > 0 && exp_data_q.size() > 0) begin
            check("m_data", m_data, exp_data_q[0]);
            check("m_last", m_last, exp_last_q[0]);
        end

        cmd_valid  = cv; cmd_addr = ca; cmd_len = cl;
        ibuf_ready = ($urandom_range(99) < p_ready);
        m_ready    = ($urandom_range(99) < p_mready);
        if (mem_addr_q.size() > 0 && $urandom_range(99) < p_rvalid) begin
            ibuf_rvalid = 1'b1;
            ibuf_rdata  = mem_word(mem_addr_q[0]);
            ibuf_rlast  = (inj_beat >= 0 && b_pushed == inj_beat) ? 1'b1 : mem_last_q[0];
        end else begin
            ibuf_rvalid = 1'b0;
            ibuf_rdata  = {$urandom, $urandom, $urandom, $urandom};
            ibuf_rlast  = 1'($urandom_range(1));
        end

        fire = ibuf_cen && ibuf_ready;
        push = ibuf_rvalid && ibuf_rready;
        pop  = m_valid && m_ready;
        acc  = cmd_valid && cmd_ready;

        done_exp = 0;
        if (fire) begin
            mem_addr_q.push_back(ibuf_addr); mem_last_q.push_back(ibuf_last);
            fire_log.push_back(ibuf_addr);   fire_last_log.push_back(ibuf_last);
            exp_data_q.push_back(mem_word(b_next_addr));
            exp_last_q.push_back(b_fired == b_len);
            b_next_addr = (b_next_addr == ADDR_W'(ADDR_MAX)) ? '0 : b_next_addr + ADDR_W'(1);
            b_fired++; tot_fired++;
        end
        if (push) begin
            if (ibuf_rlast != (b_pushed == b_len)) err_exp = 1;
            if (mem_addr_q.size() > 0) begin
                void'(mem_addr_q.pop_front()); void'(mem_last_q.pop_front());
            end
            b_pushed++; tot_pushed++;
            if (active && b_pushed == b_len + 1) begin
                active = 0; done_exp = 1; done_cnt++;
            end
        end
        if (pop) begin
            mlast_log.push_back(m_last);
            if (exp_data_q.size() > 0) begin
                void'(exp_data_q.pop_front()); void'(exp_last_q.pop_front());
            end
            tot_popped++;
        end
        if (acc) begin
            active = 1; b_len = int'(cl); b_fired = 0; b_pushed = 0;
            b_next_addr = ca; err_exp = 0;
        end
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] a, input int len, input int budget);
        bit acc;
        int cyc = 0;
        do begin
            step(1'b1, a, LEN_W'(len), acc);
            cyc++;
        end while (!acc && cyc < budget);
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: got no accept after %0d cycles, expected accept", cyc);
        end
    endtask

    task automatic finish_burst(input bit wait_empty, input int budget);
        bit acc;
        int cyc = 0;
        while ((active || (wait_empty && exp_data_q.size() > 0)) && cyc < budget) begin
            step(1'b0, '0, '0, acc);
            cyc++;
        end
        n_tests++;
        if (active || (wait_empty && exp_data_q.size() > 0)) begin
            n_fail++;
            $display("FAIL burst_timeout: got %0d beats left after %0d cycles, expected 0",
                     exp_data_q.size(), cyc);
        end
    endtask

    task automatic run_burst(input logic [ADDR_W-1:0] a, input int len, input bit wait_empty, input int budget);
        start_burst(a, len, budget);
        finish_burst(wait_empty, budget);
    endtask

    task automatic idle_steps(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_addr[4];
        int t2_addr[3];
        int d0, f0, p0;
        bit acc;
        t1_addr = '{5, 6, 7, 8};
        t2_addr = '{24574, 24575, 0};
        salt = $urandom;
        done_cnt = 0;
        model_clear();
        drive_idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("por");
        @(negedge clk) rst_n = 1;

        // 1: short burst, full rate
        fire_log.delete(); fire_last_log.delete(); mlast_log.delete(); d0 = done_cnt;
        run_burst(15'd5, 3, 1, 200);
        idle_steps(2);
        check("t1_nreq", fire_log.size(), 4);
        for (int i = 0; i < 4 && i < fire_log.size(); i++) begin
            check($sformatf("t1_addr%0d", i), fire_log[i], t1_addr[i]);
            check($sformatf("t1_last%0d", i), fire_last_log[i], (i == 3));
        end
        check("t1_nbeats", mlast_log.size(), 4);
        for (int i = 0; i < 4 && i < mlast_log.size(); i++)
            check($sformatf("t1_mlast%0d", i), mlast_log[i], (i == 3));
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_err", err, 0);

        // 2: address wrap at ADDR_MAX
        fire_log.delete(); fire_last_log.delete();
        run_burst(15'd24574, 2, 1, 200);
        check("t2_nreq", fire_log.size(), 3);
        for (int i = 0; i < 3 && i < fire_log.size(); i++)
            check($sformatf("t2_addr%0d", i), fire_log[i], t2_addr[i]);

        // 3: downstream stalled, credits cap requests at FIFO_DEPTH
        p_mready = 0; f0 = tot_fired; p0 = tot_popped;
        start_burst(15'($urandom_range(ADDR_MAX)), 15, 50);
        idle_steps(20);
        check("t3_fired_stalled", tot_fired - f0, FIFO_DEPTH);
        check("t3_cen_blocked", ibuf_cen, 0);
        p_mready = 100;
        finish_burst(1, 400);
        check("t3_beats", tot_popped - p0, 16);

        // 4: random handshakes, long burst, then mixed bursts with overlap
        p_ready = 60; p_mready = 50; p_rvalid = 70; p0 = tot_popped;
        run_burst(15'($urandom_range(ADDR_MAX)), 63, 1, 2000);
        check("t4_beats", tot_popped - p0, 64);
        run_burst(15'($urandom_range(ADDR_MAX)), 0, 1, 200);
        run_burst(15'(ADDR_MAX), 5, 1, 300);
        for (int k = 0; k < 8; k++)
            run_burst(15'($urandom_range(ADDR_MAX)), $urandom_range(20), 1'($urandom_range(1)), 800);
        finish_burst(1, 400);

        // 5: rlast asserted early on beat 2 of 4
        p_ready = 100; p_mready = 100; p_rvalid = 100;
        inj_beat = 1;
        run_burst(15'($urandom_range(ADDR_MAX)), 3, 1, 200);
        inj_beat = -1;
        idle_steps(3);
        check("t5_err_set", err, 1);
        start_burst(15'($urandom_range(ADDR_MAX)), 1, 50);
        step(1'b0, '0, '0, acc);
        check("t5_err_clr", err, 0);
        finish_burst(1, 200);

        // 6: reset in the middle of issue with two reads outstanding
        p_rvalid = 0;
        start_burst(15'd100, 10, 50);
        for (int i = 0; i < 50 && (tot_fired - tot_pushed) != 2; i++) step(1'b0, '0, '0, acc);
        check("t6_outstanding", tot_fired - tot_pushed, 2);
        @(posedge clk);
        #2 rst_n = 0;
        drive_idle();
        #1 check_reset_vals("t6_async");
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_reset_vals("t6_held");
        @(negedge clk) rst_n = 1;
        p_rvalid = 100; d0 = done_cnt; p0 = tot_popped;
        run_burst(15'd200, 5, 1, 200);
        idle_steps(2);
        check("t6_done_cnt", done_cnt - d0, 1);
        check("t6_beats", tot_popped - p0, 6);
        check("t6_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
